// File: rtl/bitwise_pkg.sv
// Shared opcode encoding for the bitwise logic pipeline.
package bitwise_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

endpackage

// File: rtl/bitwise_op_core.sv
// Purely combinational opcode-selected bitwise operator, WIDTH bits wide.
module bitwise_op_core
    import bitwise_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_e'(op_i))
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_NAND:  result_o = ~(a_i & b_i);
            OP_NOR:   result_o = ~(a_i | b_i);
            OP_XOR:   result_o = a_i ^ b_i;
            OP_XNOR:  result_o = ~(a_i ^ b_i);
            OP_ANDN:  result_o = a_i & ~b_i;
            OP_PASSA: result_o = a_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready bitwise logic pipeline with completed-op counter.
// Optional result flags (out_zero/out_ones/out_par) built when BITWISE_FLAGS_EN is defined.
module bitwise_logic_pipe
    import bitwise_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [COUNT_W-1:0] op_count,
`ifdef BITWISE_FLAGS_EN
    output logic               out_zero,
    output logic               out_ones,
    output logic               out_par,
`endif
    input  logic               cnt_clr
);

    logic                s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]     s1_op_q, s1_op_d;
    logic [WIDTH-1:0]    s1_a_q, s1_a_d;
    logic [WIDTH-1:0]    s1_b_q, s1_b_d;
    logic                s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]    s2_result_q, s2_result_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]    core_res;
    logic                adv2, load1, pop;
`ifdef BITWISE_FLAGS_EN
    logic                zero_q, zero_d, ones_q, ones_d, par_q, par_d;
`endif

    // Stage 2 can take stage 1 when it is empty or draining this cycle.
    assign adv2     = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | adv2;
    assign load1    = in_valid & in_ready;
    assign pop      = s2_valid_q & out_ready;

    bitwise_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_o (core_res)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        cnt_d       = cnt_q;
`ifdef BITWISE_FLAGS_EN
        zero_d      = zero_q;
        ones_d      = ones_q;
        par_d       = par_q;
`endif
        if (load1) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end

        if (adv2) begin
            s2_valid_d  = 1'b1;
            s2_result_d = core_res;
`ifdef BITWISE_FLAGS_EN
            zero_d      = (core_res == '0);
            ones_d      = (core_res == '1);
            par_d       = ^core_res;
`endif
        end else if (pop) begin
            s2_valid_d = 1'b0;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            cnt_q       <= '0;
`ifdef BITWISE_FLAGS_EN
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            par_q       <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            cnt_q       <= cnt_d;
`ifdef BITWISE_FLAGS_EN
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            par_q       <= par_d;
`endif
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign op_count   = cnt_q;
`ifdef BITWISE_FLAGS_EN
    assign out_zero   = zero_q;
    assign out_ones   = ones_q;
    assign out_par    = par_q;
`endif

endmodule
